// File: rtl/pipelined_shifter.sv
// ----------------------------------------------------------------------------
// pipelined_shifter
//
// Parametrised, pipelined barrel shifter for the ALU execute path.
// Supports SLL, SRL, SRA, ROL and ROR. All five functions share one
// left-shift datapath: right-hand functions bit-reverse the operand on
// entry and bit-reverse the result on exit. The log2 shift levels are
// spread evenly over STAGES register stages, and the pipeline is
// controlled by a single global stall driven by the output handshake.
//
// Parameters
//   WIDTH  : operand width, power of two, 8..64
//   SHW    : shift-amount width, derived from WIDTH (do not override)
//   STAGES : register stages (1..SHW), equal to the latency in cycles
//   TAGW   : width of the sideband tag carried with each operation
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : operation presented
//   in_ready  : operation accepted this cycle (combinational)
//   A         : operand
//   B         : shift amount (modulo WIDTH by construction)
//   SFN       : 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR, else illegal
//   in_tag    : sideband, returned unchanged
//   out_valid : result valid
//   out_ready : consumer accepts result
//   Y         : result
//   out_tag   : tag of the result
//   out_err   : SFN was illegal; Y carries A unshifted
// ----------------------------------------------------------------------------
module pipelined_shifter #(
   parameter int WIDTH  = 32,
   parameter int SHW    = $clog2(WIDTH),
   parameter int STAGES = 2,
   parameter int TAGW   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  A,
   input  logic [SHW-1:0]    B,
   input  logic [2:0]        SFN,
   input  logic [TAGW-1:0]   in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  Y,
   output logic [TAGW-1:0]   out_tag,
   output logic              out_err
);

   localparam int LAST = STAGES - 1;

   // Mirror a word end to end; used on entry and exit of right-hand functions.
   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = d[WIDTH-1-i];
      end
      return r;
   endfunction

   // One left-shift level. The word below the operand supplies the bits
   // that enter at the bottom: a copy of the operand for rotates (circular),
   // otherwise a replicated fill bit (0 for logical, sign for arithmetic).
   function automatic logic [WIDTH-1:0] shl_level(input logic [WIDTH-1:0] d,
                                                  input int unsigned      sh,
                                                  input logic             rot,
                                                  input logic             fill);
      logic [2*WIDTH-1:0] ext;
      ext = {d, (rot ? d : {WIDTH{fill}})};
      ext = ext << sh;
      return ext[2*WIDTH-1:WIDTH];
   endfunction

   // Stage that owns shift level k; spreads the levels evenly over STAGES.
   function automatic int stage_of(input int k);
      return (k * STAGES) / SHW;
   endfunction

   // ---------------------------------------------------------------------
   // Entry decode
   // ---------------------------------------------------------------------
   logic              legal_s;
   logic              fill_s;
   logic              rev_s;
   logic              rot_s;
   logic [SHW-1:0]    amt_s;
   logic [WIDTH-1:0]  ent_dat_s;

   // Classify SFN, pick the fill bit and prepare the (possibly reversed) operand.
   always_comb begin
      legal_s = 1'b0;
      fill_s  = 1'b0;
      case (SFN)
         3'b000, 3'b001, 3'b100, 3'b101: begin
            legal_s = 1'b1;
            fill_s  = 1'b0;
         end
         3'b011: begin
            // SRA fills with the MSB of the original, unreversed operand.
            legal_s = 1'b1;
            fill_s  = A[WIDTH-1];
         end
         default: begin
            legal_s = 1'b0;
            fill_s  = 1'b0;
         end
      endcase
      rev_s = SFN[0];
      rot_s = SFN[2];
      // An illegal function passes A through: no shift, and any entry
      // reversal is undone by the matching exit reversal.
      if (legal_s) begin
         amt_s = B;
      end else begin
         amt_s = {SHW{1'b0}};
      end
      if (rev_s) begin
         ent_dat_s = bit_rev(A);
      end else begin
         ent_dat_s = A;
      end
   end

   // ---------------------------------------------------------------------
   // Pipeline state: one register set after the last level of each stage
   // ---------------------------------------------------------------------
   logic [STAGES-1:0]  vld_r;
   logic [WIDTH-1:0]   dat_r  [STAGES];
   logic [SHW-1:0]     amt_r  [STAGES];
   logic               rot_r  [STAGES];
   logic               fill_r [STAGES];
   logic               rev_r  [STAGES];
   logic               err_r  [STAGES];
   logic [TAGW-1:0]    tag_r  [STAGES];

   // Stage inputs: stage 0 is fed by the entry decode, later stages by
   // the register of the stage before them.
   logic [STAGES-1:0]  in_vld_s;
   logic [WIDTH-1:0]   in_dat_s  [STAGES];
   logic [SHW-1:0]     in_amt_s  [STAGES];
   logic               in_rot_s  [STAGES];
   logic               in_fill_s [STAGES];
   logic               in_rev_s  [STAGES];
   logic               in_err_s  [STAGES];
   logic [TAGW-1:0]    in_tag_s  [STAGES];
   logic [WIDTH-1:0]   nxt_dat_s [STAGES];

   logic               advance_s;

   // Global stall: everything moves when the output slot is free or draining.
   always_comb begin
      advance_s = out_ready | ~vld_r[LAST];
   end

   assign in_ready = advance_s;

   // Route each stage's inputs from the entry decode or the previous register.
   always_comb begin
      in_vld_s     = {STAGES{1'b0}};
      in_vld_s[0]  = in_valid;
      in_dat_s[0]  = ent_dat_s;
      in_amt_s[0]  = amt_s;
      in_rot_s[0]  = rot_s;
      in_fill_s[0] = fill_s;
      in_rev_s[0]  = rev_s;
      in_err_s[0]  = ~legal_s;
      in_tag_s[0]  = in_tag;
      for (int s = 1; s < STAGES; s++) begin
         in_vld_s[s]  = vld_r[s-1];
         in_dat_s[s]  = dat_r[s-1];
         in_amt_s[s]  = amt_r[s-1];
         in_rot_s[s]  = rot_r[s-1];
         in_fill_s[s] = fill_r[s-1];
         in_rev_s[s]  = rev_r[s-1];
         in_err_s[s]  = err_r[s-1];
         in_tag_s[s]  = tag_r[s-1];
      end
   end

   // Apply the shift levels owned by each stage; level k shifts by 2^k.
   always_comb begin : p_levels
      logic [WIDTH-1:0] cur;
      cur = {WIDTH{1'b0}};
      for (int s = 0; s < STAGES; s++) begin
         cur = in_dat_s[s];
         for (int k = 0; k < SHW; k++) begin
            if ((stage_of(k) == s) && in_amt_s[s][k]) begin
               cur = shl_level(cur, 32'd1 << k, in_rot_s[s], in_fill_s[s]);
            end else begin
               cur = cur;
            end
         end
         nxt_dat_s[s] = cur;
      end
   end

   // Stage registers: cleared by reset, loaded together on advance, held on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_r <= {STAGES{1'b0}};
         for (int s = 0; s < STAGES; s++) begin
            dat_r[s]  <= {WIDTH{1'b0}};
            amt_r[s]  <= {SHW{1'b0}};
            rot_r[s]  <= 1'b0;
            fill_r[s] <= 1'b0;
            rev_r[s]  <= 1'b0;
            err_r[s]  <= 1'b0;
            tag_r[s]  <= {TAGW{1'b0}};
         end
      end else if (advance_s) begin
         vld_r <= in_vld_s;
         for (int s = 0; s < STAGES; s++) begin
            dat_r[s]  <= nxt_dat_s[s];
            amt_r[s]  <= in_amt_s[s];
            rot_r[s]  <= in_rot_s[s];
            fill_r[s] <= in_fill_s[s];
            rev_r[s]  <= in_rev_s[s];
            err_r[s]  <= in_err_s[s];
            tag_r[s]  <= in_tag_s[s];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: taken from the final register; exit reversal is wiring only.
   // ---------------------------------------------------------------------
   assign out_valid = vld_r[LAST];
   assign Y         = rev_r[LAST] ? bit_rev(dat_r[LAST]) : dat_r[LAST];
   assign out_tag   = tag_r[LAST];
   assign out_err   = err_r[LAST];

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;

   localparam logic [2:0] F_SLL = 3'b000;
   localparam logic [2:0] F_SRL = 3'b001;
   localparam logic [2:0] F_ILA = 3'b010;
   localparam logic [2:0] F_SRA = 3'b011;
   localparam logic [2:0] F_ROL = 3'b100;
   localparam logic [2:0] F_ROR = 3'b101;
   localparam logic [2:0] F_ILB = 3'b110;
   localparam logic [2:0] F_ILC = 3'b111;

   typedef struct {
      logic [63:0] y;
      logic [3:0]  tag;
      logic        err;
      int          due;
      bit          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [2:0]  iv;
   logic [2:0]  or_;
   logic [2:0]  ir;
   logic [2:0]  ov;
   logic [2:0]  er;
   logic [63:0] a_bus;
   logic [5:0]  b_bus;
   logic [2:0]  sfn_bus;
   logic [3:0]  tag_bus;
   logic [31:0] y0;
   logic [7:0]  y1;
   logic [63:0] y2;
   logic [63:0] yv [3];
   logic [3:0]  tg [3];

   int   cyc;
   int   n_pass;
   int   n_total;
   int   st_lo;
   int   st_hi;
   exp_t q [3][$];

   pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAGW(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .A(a_bus[31:0]), .B(b_bus[4:0]), .SFN(sfn_bus), .in_tag(tag_bus),
      .out_valid(ov[0]), .out_ready(or_[0]), .Y(y0), .out_tag(tg[0]), .out_err(er[0]));

   pipelined_shifter #(.WIDTH(8), .STAGES(1), .TAGW(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .A(a_bus[7:0]), .B(b_bus[2:0]), .SFN(sfn_bus), .in_tag(tag_bus),
      .out_valid(ov[1]), .out_ready(or_[1]), .Y(y1), .out_tag(tg[1]), .out_err(er[1]));

   pipelined_shifter #(.WIDTH(64), .STAGES(6), .TAGW(4)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .A(a_bus), .B(b_bus), .SFN(sfn_bus), .in_tag(tag_bus),
      .out_valid(ov[2]), .out_ready(or_[2]), .Y(y2), .out_tag(tg[2]), .out_err(er[2]));

   assign yv[0] = {32'd0, y0};
   assign yv[1] = {56'd0, y1};
   assign yv[2] = y2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int sel);
      return (sel == 0) ? 2 : ((sel == 1) ? 1 : 6);
   endfunction

   // Independent 64-bit reference built from native shift operators.
   function automatic logic [63:0] ref64(input logic [63:0] a, input logic [5:0] b, input logic [2:0] f);
      logic signed [63:0] sa;
      sa = a;
      case (f)
         F_SLL:   return a << b;
         F_SRL:   return a >> b;
         F_SRA:   return sa >>> b;
         F_ROL:   return (b == 6'd0) ? a : ((a << b) | (a >> (7'd64 - {1'b0, b})));
         F_ROR:   return (b == 6'd0) ? a : ((a >> b) | (a << (7'd64 - {1'b0, b})));
         default: return a;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic tick();
      @(negedge clk);
      or_ = (cyc >= st_lo && cyc < st_hi) ? 3'b000 : 3'b111;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         iv = 3'b000;
      end
   endtask

   task automatic send(input int sel, input logic [63:0] a, input logic [5:0] b, input logic [2:0] f,
                       input logic [3:0] t, input logic [63:0] y, input bit lat);
      int   guard;
      exp_t e;
      tick();
      a_bus = a; b_bus = b; sfn_bus = f; tag_bus = t;
      iv = 3'b000; iv[sel] = 1'b1;
      guard = 0;
      while (!ir[sel] && guard < 40) begin
         tick();
         guard++;
      end
      if (guard >= 40) begin
         chk("send_timeout", 64'(guard), 64'd0);
      end else begin
         e.y = y; e.tag = t; e.err = (f == F_ILA || f == F_ILB || f == F_ILC);
         e.due = cyc + lat_of(sel); e.lat = lat;
         q[sel].push_back(e);
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && g < 100) begin
         idle(1);
         g++;
      end
      for (int d = 0; d < 3; d++) chk($sformatf("d%0d_drained", d), 64'(q[d].size()), 64'd0);
   endtask

   // Monitor: compares every presented result against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            if (ov[d]) begin
               if (q[d].size() == 0) begin
                  chk($sformatf("d%0d_unexpected_out", d), 64'(ov[d]), 64'd0);
               end else begin
                  e = q[d][0];
                  chk($sformatf("d%0d_Y", d), yv[d], e.y);
                  chk($sformatf("d%0d_tag", d), 64'(tg[d]), 64'(e.tag));
                  chk($sformatf("d%0d_err", d), 64'(er[d]), 64'(e.err));
                  if (or_[d]) begin
                     if (e.lat) chk($sformatf("d%0d_latency_cycle", d), 64'(cyc), 64'(e.due));
                     void'(q[d].pop_front());
                  end else begin
                     chk($sformatf("d%0d_in_ready_stall", d), 64'(ir[d]), 64'd0);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      cyc = 0; n_pass = 0; n_total = 0; st_lo = 0; st_hi = 0;
      rst = 1'b1; iv = 3'b000; or_ = 3'b111;
      a_bus = 64'd0; b_bus = 6'd0; sfn_bus = 3'd0; tag_bus = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_Y", 64'(y0), 64'd0);
      chk("rst_out_tag", 64'(tg[0]), 64'd0);
      chk("rst_out_err", 64'(er[0]), 64'd0);
      chk("rst_in_ready", 64'(ir[0]), 64'd1);

      // WIDTH=32, STAGES=2 directed vectors
      send(0, 64'h0000_0001, 6'd31, F_SLL, 4'd1, 64'h8000_0000, 1);
      idle(4);
      send(0, 64'h8000_0000, 6'd4,  F_SRA, 4'd2, 64'hF800_0000, 1);
      send(0, 64'h8000_0000, 6'd4,  F_SRL, 4'd3, 64'h0800_0000, 1);
      send(0, 64'h0000_0001, 6'd1,  F_ROR, 4'd4, 64'h8000_0000, 1);
      send(0, 64'h8000_0001, 6'd4,  F_ROL, 4'd6, 64'h0000_0018, 1);
      send(0, 64'h1234_5678, 6'd8,  F_ILB, 4'd5, 64'h1234_5678, 1);
      send(0, 64'h0000_00F0, 6'd3,  F_ILC, 4'd7, 64'h0000_00F0, 1);
      send(0, 64'h0000_00F0, 6'd3,  F_ILA, 4'd8, 64'h0000_00F0, 1);
      send(0, 64'h8000_0000, 6'd0,  F_SRA, 4'd9, 64'h8000_0000, 1);
      send(0, 64'h8000_0000, 6'd31, F_SRA, 4'd10, 64'hFFFF_FFFF, 1);
      send(0, 64'h4000_0000, 6'd31, F_SRA, 4'd11, 64'h0000_0000, 1);
      send(0, 64'hDEAD_BEEF, 6'd0,  F_ROR, 4'd12, 64'hDEAD_BEEF, 1);
      send(0, 64'h1234_5678, 6'd8,  F_ROL, 4'd13, 64'h3456_7812, 1);
      idle(3);

      // Back-to-back, full throughput
      for (int i = 0; i < 8; i++) send(0, 64'h0000_0001, 6'(i), F_SLL, 4'(i), 64'(32'h1 << i), 1);
      idle(3);

      // Back-to-back with a 3-cycle output stall mid-stream
      st_lo = cyc + 4;
      st_hi = st_lo + 3;
      for (int i = 0; i < 8; i++) send(0, 64'h8000_0000, 6'(i), F_SRL, 4'(8 + i), 64'(32'h8000_0000 >> i), 0);
      drain();
      st_lo = 0; st_hi = 0;

      // Asynchronous reset with two operations in flight
      send(0, 64'h0000_0011, 6'd2, F_SLL, 4'd3, 64'h0000_0044, 0);
      send(0, 64'h0000_0022, 6'd2, F_SLL, 4'd4, 64'h0000_0088, 0);
      @(posedge clk);
      #2;
      iv = 3'b000;
      chk("rst_inflight_valid_before", 64'(ov[0]), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_async_Y", 64'(y0), 64'd0);
      q[0].delete();
      @(negedge clk);
      #3;
      rst = 1'b0;
      idle(10);
      chk("post_rst_no_stale", 64'(ov[0]), 64'd0);

      // WIDTH=8, STAGES=1
      send(1, 64'h81, 6'd1, F_ROL, 4'd1, 64'h03, 1);
      send(1, 64'h80, 6'd7, F_SRA, 4'd2, 64'hFF, 1);
      send(1, 64'h01, 6'd7, F_ROR, 4'd3, 64'h02, 1);
      send(1, 64'h80, 6'd0, F_SRL, 4'd4, 64'h80, 1);
      send(1, 64'h5A, 6'd3, F_ILA, 4'd5, 64'h5A, 1);
      send(1, 64'hFF, 6'd4, F_SLL, 4'd6, 64'hF0, 1);
      drain();

      // WIDTH=64, STAGES=6: directed boundary plus random ops against ref64
      send(2, 64'h8000_0000_0000_0000, 6'd63, F_SRA, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      send(2, 64'h8000_0000_0000_0001, 6'd4,  F_ROL, 4'd2, 64'h0000_0000_0000_0018, 1);
      for (int i = 0; i < 30; i++) begin
         logic [63:0] a;
         logic [5:0]  b;
         logic [2:0]  f;
         a = {$urandom(), $urandom()};
         b = 6'($urandom_range(0, 63));
         f = 3'($urandom_range(0, 7));
         send(2, a, b, f, 4'(i), ref64(a, b, f), 1);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
